component_elastic_delay: RTL and testbench

COMPONENT_ELASTIC_DELAY -- requirements
Module: component_elastic_delay

---
 rtl/component_elastic_delay.sv | 97 +++++++++
 tb/tb_component_elastic_delay.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/component_elastic_delay.sv
// component_elastic_delay: CYCLES-stage elastic pipeline whose bubbles collapse under back-pressure.
// Define COMPONENT_ELASTIC_DELAY_COUNT_EN to add the registered occupancy output.
module component_elastic_delay #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
  ,
  output logic [((CYCLES == 0) ? 1 : $clog2(CYCLES + 1))-1:0] occupancy
`endif
);

  if (CYCLES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign data_out  = data_in;
    assign in_ready  = out_ready;
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
    assign occupancy = '0;
`endif
  end else begin : g_pipe
    logic [CYCLES-1:0] v_q;
    logic [CYCLES-1:0] v_d;
    logic [CYCLES-1:0] pass;
    logic [WIDTH-1:0]  data_q [CYCLES];
    logic [WIDTH-1:0]  data_d [CYCLES];

    // pass[s]: stage s hands its content (word or bubble) onward this cycle.
    always_comb begin
      pass = '0;
      pass[CYCLES-1] = out_ready;
      for (int s = CYCLES - 2; s >= 0; s--) begin
        pass[s] = ~v_q[s+1] | pass[s+1];
      end
    end

    assign in_ready  = ~v_q[0] | pass[0];
    assign out_valid = v_q[CYCLES-1];
    assign data_out  = data_q[CYCLES-1];

    // Data registers only load when a valid word arrives, so bubbles leave data untouched.
    always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (in_ready) begin
        v_d[0] = in_valid;
        if (in_valid) data_d[0] = data_in;
      end
      for (int s = 1; s < CYCLES; s++) begin
        if (pass[s-1]) begin
          v_d[s] = v_q[s-1];
          if (v_q[s-1]) data_d[s] = data_q[s-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= '0;
        for (int s = 0; s < CYCLES; s++) data_q[s] <= '0;
      end else begin
        v_q    <= v_d;
        data_q <= data_d;
      end
    end

`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
    localparam int OCC_W = $clog2(CYCLES + 1);
    logic [OCC_W-1:0] occ_q;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = v_q[CYCLES-1] & out_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        occ_q <= '0;
      end else if (in_xfer && !out_xfer) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (out_xfer && !in_xfer) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end

    assign occupancy = occ_q;
`endif
  end

endmodule

// File: tb/tb_component_elastic_delay.sv
// Directed bench for component_elastic_delay (CYCLES=4 instance plus a CYCLES=0 bypass instance).
module tb_component_elastic_delay;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] data_in, data_out;
  logic       in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0] data_in0, data_out0;
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
  logic [2:0] occupancy;
  logic       occupancy0;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  component_elastic_delay #(.WIDTH(8), .CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
    , .occupancy(occupancy)
`endif
  );

  component_elastic_delay #(.WIDTH(8), .CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .data_in(data_in0),
    .out_valid(out_valid0), .out_ready(out_ready0), .data_out(data_out0)
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
    , .occupancy(occupancy0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [7:0] din, input logic ordy);
    in_valid  = iv;
    data_in   = din;
    out_ready = ordy;
    #1;
  endtask

  task automatic observe();
    if (out_valid && out_ready) got_q.push_back(data_out);
  endtask

  task automatic check_words(input string tag, input logic [7:0] first, input int n);
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check({tag, "_word"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(first + 8'(i)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    in_valid0 = 1'b0; data_in0 = '0; out_ready0 = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
    check("rst_occupancy", 32'(occupancy), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Streaming: 0x01..0x08 back to back with out_ready high.
    for (int c = 0; c < 13; c++) begin
      set_in(c < 8, 8'(c + 1), 1'b1);
      if (c < 8) check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_out_valid", 32'(out_valid), 32'(c >= 4 && c < 12));
      if (c >= 4 && c < 12) check("stream_data", 32'(data_out), 32'(c - 3));
      tick();
    end

    // Back-pressure fill: 0xA0..0xA3 accepted, then stall with 0xA0 held.
    for (int c = 0; c < 6; c++) begin
      set_in(1'b1, 8'hA0 + 8'((c < 4) ? c : 4), 1'b0);
      check("fill_in_ready", 32'(in_ready), 32'(c < 4));
      if (c >= 4) begin
        check("fill_out_valid", 32'(out_valid), 32'd1);
        check("fill_data_stable", 32'(data_out), 32'hA0);
      end
      tick();
    end
    got_q.delete();
    idx = 4;
    for (int c = 0; c < 10; c++) begin
      set_in(idx < 6, 8'hA0 + 8'(idx), 1'b1);
      if (c == 0) check("drain_in_ready", 32'(in_ready), 32'd1);
      observe();
      if (in_valid && in_ready) idx++;
      tick();
    end
    check_words("drain", 8'hA0, 6);

    // Full pipe with simultaneous in/out for 3 cycles.
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 8'hB0 + 8'(c), 1'b0);
      check("full_fill_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
    check("full_occupancy", 32'(occupancy), 32'd4);
`endif
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 8'hB4 + 8'(c), 1'b1);
      check("both_in_ready", 32'(in_ready), 32'd1);
      check("both_out_valid", 32'(out_valid), 32'd1);
      check("both_data", 32'(data_out), 32'(8'hB0 + 8'(c)));
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
      check("both_occupancy", 32'(occupancy), 32'd4);
`endif
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0);
    check("both_after_data", 32'(data_out), 32'hB3);
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
    check("both_after_occupancy", 32'(occupancy), 32'd4);
`endif
    got_q.delete();
    for (int c = 0; c < 8; c++) begin
      set_in(1'b0, 8'h00, 1'b1);
      observe();
      tick();
    end
    check_words("both_drain", 8'hB3, 4);
`ifdef COMPONENT_ELASTIC_DELAY_COUNT_EN
    check("empty_occupancy", 32'(occupancy), 32'd0);
`endif

    // Single word with toggling out_ready.
    got_q.delete();
    set_in(1'b1, 8'h5A, 1'b0);
    tick();
    for (int c = 1; c < 4; c++) begin
      set_in(1'b0, 8'h00, 1'b0);
      tick();
    end
    for (int c = 4; c < 8; c++) begin
      set_in(1'b0, 8'h00, (c % 2) == 1);
      check("single_out_valid", 32'(out_valid), 32'(c < 6));
      if (c < 6) check("single_data", 32'(data_out), 32'h5A);
      observe();
      tick();
    end
    check_words("single", 8'h5A, 1);

    // Asynchronous reset with 3 words in flight.
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 8'hC1 + 8'(c), 1'b0);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0);
    check("pre_rst_data", 32'(data_out), 32'hC1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_data_out", 32'(data_out), 32'h00);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst = 1'b1;
    tick();
    got_q.delete();
    for (int c = 0; c < 7; c++) begin
      set_in(c == 0, 8'h33, 1'b1);
      check("post_rst_out_valid", 32'(out_valid), 32'(c == 4));
      if (c == 4) check("post_rst_data", 32'(data_out), 32'h33);
      observe();
      tick();
    end
    check_words("post_rst", 8'h33, 1);

    // CYCLES=0 bypass.
    in_valid0 = 1'b1; data_in0 = 8'h7E; out_ready0 = 1'b0;
    #1;
    check("bypass_out_valid", 32'(out_valid0), 32'd1);
    check("bypass_data_out", 32'(data_out0), 32'h7E);
    check("bypass_in_ready_lo", 32'(in_ready0), 32'd0);
    out_ready0 = 1'b1;
    #1;
    check("bypass_in_ready_hi", 32'(in_ready0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
